if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode.
- Owns the PC register, the next-PC selection and the IF/ID pipeline register.
- Consumes the PC_Write / IF_ID_Write / IF_ID_Flush controls from the hazard/forwarding unit, plus jump and branch redirects from ID and EX.
- Latches pending interrupts and tags the fetched slot so decode can raise the interrupt (XADR) path.

Parameters:
- RESET_PC, 32'h80000000, PC value after reset (supervisor mode, bit 31 set).
- ILLOP_ADDR, 32'h80000004, target for ID_PCSrc=4 (illegal opcode).
- XADR_ADDR, 32'h80000008, target for ID_PCSrc=5 (interrupt/exception).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- PC_Write  in  1  1 = PC may update; 0 = hold PC (load-use stall).
- IF_ID_Write  in  1  1 = IF/ID register may load; 0 = hold.
- IF_ID_Flush  in  1  1 = load a bubble into IF/ID.
- ID_PCSrc  in  3  decode next-PC select: 2 = J/JAL, 3 = JR/JALR, 4 = ILLOP, 5 = XADR; 0/1 = no ID redirect.
- ID_JumpTarget  in  26  instruction[25:0] of the decode-stage instruction.
- ID_JRTarget  in  32  forwarded Rs value for JR (already selected via ForwardJR).
- ID_PC4  in  32  PC+4 of the decode-stage instruction.
- EX_BranchTaken  in  1  EX branch resolved taken (ID_EX_PCSrc==1 && ALUOut0).
- EX_BranchTarget  in  32  branch target computed in EX.
- IRQ  in  1  level interrupt request from the timer/peripheral.
- InstMem_Data  in  32  instruction read combinationally at InstMem_Addr.
- InstMem_Addr  out  32  current PC.
- IF_ID_Instr  out  32  registered instruction.
- IF_ID_PC4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  0 = slot is a bubble.
- IF_ID_Irq  out  1  1 = decode must treat this slot as an interrupt (PCSrc=5).

Behaviour:
- Reset (sync): PC=RESET_PC, IF_ID_Instr=0, IF_ID_PC4=0, IF_ID_Valid=0, IF_ID_Irq=0, irq_pending=0.
- PC4 = {PC[31], PC[30:0]+31'd4}. The supervisor bit is never changed by increment, and wrap-around stays inside the half-space.
- Next-PC priority, highest first:
  1. reset.
  2. EX_BranchTaken: PC = {PC[31] & EX_BranchTarget[31], EX_BranchTarget[30:0]}. Applies even if PC_Write=0, because a taken branch kills the stalled younger instructions.
  3. ID_PCSrc=2: PC = {ID_PC4[31:28], ID_JumpTarget, 2'b00}.
  4. ID_PCSrc=3: PC = {PC[31] & ID_JRTarget[31], ID_JRTarget[30:0]}. User code can never set bit 31.
  5. ID_PCSrc=4: PC = ILLOP_ADDR.
  6. ID_PCSrc=5: PC = XADR_ADDR.
  7. PC_Write=0: hold.
  8. Otherwise PC = PC4.
- ID redirects (PCSrc 2..5) ignore PC_Write, since the hazard unit never stalls on them. EX_BranchTaken overrides a simultaneous ID redirect.
- IF/ID register priority:
  1. reset.
  2. IF_ID_Flush: Instr=0 (nop), Valid=0, Irq=0, PC4=current PC4.
  3. IF_ID_Write=0: hold all fields.
  4. Otherwise: Instr=InstMem_Data, PC4=PC4, Valid=1, Irq=irq_take.
- The bubble keeps a real PC4 so that an EPC taken from a bubble slot is still meaningful.
- Interrupt latch:
  - irq_pending sets when IRQ=1 and PC[31]=0; it holds until consumed.
  - irq_take = irq_pending && IF_ID_Write && !IF_ID_Flush && !EX_BranchTaken && ID_PCSrc not in {2..5}.
  - On irq_take: IF_ID_Irq=1, IF_ID_Instr=0 (the fetched word is discarded), IF_ID_PC4 = current PC (not PC4), so the interrupted instruction is re-executed after return.
  - On irq_take, PC holds (it does not advance); decode then drives ID_PCSrc=5 next cycle.
  - irq_pending clears on irq_take, and on reset.
  - IRQ seen while PC[31]=1 is ignored, not queued.
- Combinational path: InstMem_Addr = PC. Latency: one cycle from PC to IF/ID outputs.

Test Plan:
- Reset, then 3 free-run cycles with PC_Write=1, IF_ID_Write=1 -> InstMem_Addr 80000000, 80000004, 80000008, 8000000C; IF_ID_PC4 lags one cycle; Valid=1 after the first load.
- Load-use stall: PC=00000010, PC_Write=0, IF_ID_Write=0 for 1 cycle -> PC stays 00000010, IF_ID fields unchanged; PC=00000014 the following cycle.
- Redirect priority: EX_BranchTaken=1, target 00000100, with ID_PCSrc=2 and IF_ID_Flush=1 in the same cycle -> PC=00000100, IF_ID_Instr=0, Valid=0.
- JR privilege: PC=00000040, ID_PCSrc=3, ID_JRTarget=80000020 -> PC=00000020. The same input with PC=80000040 -> PC=80000020.
- Interrupt take: PC=00000200, IRQ pulsed 1 cycle, no redirects -> next edge: IF_ID_Irq=1, IF_ID_PC4=00000200, Instr=0, PC=00000200. Then ID_PCSrc=5 -> PC=80000008; a second IRQ while PC[31]=1 is not taken.
- Interrupt blocked by flush: irq_pending=1 with IF_ID_Flush=1 -> Irq=0 that cycle; the interrupt is taken on the first non-flushed cycle after.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, interrupt latch and
// the IF/ID pipeline register feeding decode.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [31:0] XADR_ADDR  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Write,
    input  logic        IF_ID_Write,
    input  logic        IF_ID_Flush,
    input  logic [2:0]  ID_PCSrc,
    input  logic [25:0] ID_JumpTarget,
    input  logic [31:0] ID_JRTarget,
    input  logic [31:0] ID_PC4,
    input  logic        EX_BranchTaken,
    input  logic [31:0] EX_BranchTarget,
    input  logic        IRQ,
    input  logic [31:0] InstMem_Data,
    output logic [31:0] InstMem_Addr,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic        IF_ID_Irq
);

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc_next;
    logic        irq_pending;
    logic        irq_seen;
    logic        irq_take;
    logic        id_redirect;

    // Increment never touches the supervisor bit; wrap stays in the half-space.
    assign pc4 = {pc[31], pc[30:0] + 31'd4};

    assign id_redirect = (ID_PCSrc >= 3'd2) && (ID_PCSrc <= 3'd5);

    // A request arriving this cycle can be taken immediately; user mode only.
    assign irq_seen = irq_pending | (IRQ & ~pc[31]);
    assign irq_take = irq_seen & IF_ID_Write & ~IF_ID_Flush
                    & ~EX_BranchTaken & ~id_redirect;

    assign InstMem_Addr = pc;

    always_comb begin
        pc_next = pc4;
        if (EX_BranchTaken) begin
            pc_next = {pc[31] & EX_BranchTarget[31], EX_BranchTarget[30:0]};
        end else begin
            case (ID_PCSrc)
                3'd2:    pc_next = {ID_PC4[31:28], ID_JumpTarget, 2'b00};
                3'd3:    pc_next = {pc[31] & ID_JRTarget[31], ID_JRTarget[30:0]};
                3'd4:    pc_next = ILLOP_ADDR;
                3'd5:    pc_next = XADR_ADDR;
                default: begin
                    // Taking an interrupt holds PC so the instruction re-executes.
                    if (!PC_Write || irq_take) begin
                        pc_next = pc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            irq_pending <= 1'b0;
            IF_ID_Instr <= 32'd0;
            IF_ID_PC4   <= 32'd0;
            IF_ID_Valid <= 1'b0;
            IF_ID_Irq   <= 1'b0;
        end else begin
            pc          <= pc_next;
            irq_pending <= irq_seen & ~irq_take;
            if (IF_ID_Flush) begin
                // Bubble still carries a real PC4 for a meaningful EPC.
                IF_ID_Instr <= 32'd0;
                IF_ID_PC4   <= pc4;
                IF_ID_Valid <= 1'b0;
                IF_ID_Irq   <= 1'b0;
            end else if (IF_ID_Write) begin
                if (irq_take) begin
                    IF_ID_Instr <= 32'd0;
                    IF_ID_PC4   <= pc;
                    IF_ID_Valid <= 1'b1;
                    IF_ID_Irq   <= 1'b1;
                end else begin
                    IF_ID_Instr <= InstMem_Data;
                    IF_ID_PC4   <= pc4;
                    IF_ID_Valid <= 1'b1;
                    IF_ID_Irq   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, a hand-written reset/interrupt
// sequence, then randomized cycles checked against a reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        ifid_write;
    logic        flush;
    logic [2:0]  pcsrc;
    logic [25:0] jt;
    logic [31:0] jr;
    logic [31:0] idpc4;
    logic        br;
    logic [31:0] brt;
    logic        irq;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] o_instr;
    logic [31:0] o_pc4;
    logic        o_valid;
    logic        o_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk             (clk),
        .reset           (rst),
        .PC_Write        (pc_write),
        .IF_ID_Write     (ifid_write),
        .IF_ID_Flush     (flush),
        .ID_PCSrc        (pcsrc),
        .ID_JumpTarget   (jt),
        .ID_JRTarget     (jr),
        .ID_PC4          (idpc4),
        .EX_BranchTaken  (br),
        .EX_BranchTarget (brt),
        .IRQ             (irq),
        .InstMem_Data    (imem_data),
        .InstMem_Addr    (imem_addr),
        .IF_ID_Instr     (o_instr),
        .IF_ID_PC4       (o_pc4),
        .IF_ID_Valid     (o_valid),
        .IF_ID_Irq       (o_irq)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
    endfunction

    assign imem_data = mem_word(imem_addr);

    // ---------------- reference model ----------------
    logic [31:0] m_pc = 32'h8000_0000, m_instr = 0, m_pc4 = 0;
    logic        m_valid = 0, m_irq = 0, m_pend = 0;
    logic [31:0] n_pc, n_instr, n_pc4;
    logic        n_valid, n_irq, n_pend;

    task automatic model_compute();
        logic [31:0] seq;
        logic        want, take, redirect;
        seq      = {m_pc[31], m_pc[30:0] + 31'd4};
        want     = m_pend || (irq && !m_pc[31]);
        redirect = (pcsrc == 3'd2) || (pcsrc == 3'd3) || (pcsrc == 3'd4) || (pcsrc == 3'd5);
        take     = want && ifid_write && !flush && !br && !redirect;
        if (br)                n_pc = {m_pc[31] & brt[31], brt[30:0]};
        else if (pcsrc == 3'd2) n_pc = {idpc4[31:28], jt, 2'b00};
        else if (pcsrc == 3'd3) n_pc = {m_pc[31] & jr[31], jr[30:0]};
        else if (pcsrc == 3'd4) n_pc = 32'h8000_0004;
        else if (pcsrc == 3'd5) n_pc = 32'h8000_0008;
        else if (!pc_write || take) n_pc = m_pc;
        else                   n_pc = seq;
        {n_instr, n_pc4, n_valid, n_irq} = {m_instr, m_pc4, m_valid, m_irq};
        if (flush)           {n_instr, n_pc4, n_valid, n_irq} = {32'd0, seq, 1'b0, 1'b0};
        else if (take)       {n_instr, n_pc4, n_valid, n_irq} = {32'd0, m_pc, 1'b1, 1'b1};
        else if (ifid_write) {n_instr, n_pc4, n_valid, n_irq} = {mem_word(m_pc), seq, 1'b1, 1'b0};
        n_pend = want && !take;
        if (rst) begin
            n_pc = 32'h8000_0000;
            {n_instr, n_pc4, n_valid, n_irq, n_pend} = '0;
        end
    endtask

    task automatic tick();
        model_compute();
        @(posedge clk);
        #1;
        {m_pc, m_instr, m_pc4, m_valid, m_irq, m_pend} = {n_pc, n_instr, n_pc4, n_valid, n_irq, n_pend};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " pc"},    imem_addr, m_pc);
        check({tag, " instr"}, o_instr,   m_instr);
        check({tag, " pc4"},   o_pc4,     m_pc4);
        check({tag, " valid"}, {31'd0, o_valid}, {31'd0, m_valid});
        check({tag, " irq"},   {31'd0, o_irq},   {31'd0, m_irq});
    endtask

    task automatic idle();
        {rst, flush, br, irq} = '0;
        {pc_write, ifid_write} = 2'b11;
        pcsrc = 3'd0; jt = '0; jr = '0; idpc4 = '0; brt = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, pcw, ifw, fl;
        logic [2:0]  src;
        logic [25:0] jt;
        logic [31:0] jr;
        logic        br;
        logic [31:0] brt;
        logic        irq;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic        e_valid, e_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(input logic r, pcw, ifw, fl, input logic [2:0] src,
                                 input logic [25:0] j, input logic [31:0] jrt,
                                 input logic b, input logic [31:0] bt, input logic iq,
                                 input logic [31:0] epc, ei, ep4, input logic ev, eq);
        vec_t v;
        v.rst = r; v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.src = src; v.jt = j; v.jr = jrt;
        v.br = b; v.brt = bt; v.irq = iq;
        v.e_pc = epc; v.e_instr = ei; v.e_pc4 = ep4; v.e_valid = ev; v.e_irq = eq;
        return v;
    endfunction

    initial begin
        idle();
        // reset and free run
        vecs.push_back(row(1,1,1,0,0,0,0,0,0,0, 32'h8000_0000, 0, 0, 0, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h8000_0004, mem_word(32'h8000_0000), 32'h8000_0004, 1, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h8000_0008, mem_word(32'h8000_0004), 32'h8000_0008, 1, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h8000_000C, mem_word(32'h8000_0008), 32'h8000_000C, 1, 0));
        // J to 0x10, load-use stall, resume
        vecs.push_back(row(0,1,1,0,2,26'h4,0,0,0,0, 32'h0000_0010, mem_word(32'h8000_000C), 32'h8000_0010, 1, 0));
        vecs.push_back(row(0,0,0,0,0,0,0,0,0,0, 32'h0000_0010, mem_word(32'h8000_000C), 32'h8000_0010, 1, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h0000_0014, mem_word(32'h0000_0010), 32'h0000_0014, 1, 0));
        // branch beats ID jump, flush gives bubble with real PC4
        vecs.push_back(row(0,1,1,1,2,26'h3F,0,1,32'h100,0, 32'h0000_0100, 0, 32'h0000_0018, 0, 0));
        // JR privilege masking from user and supervisor PCs
        vecs.push_back(row(0,1,1,0,2,26'h10,0,0,0,0, 32'h0000_0040, mem_word(32'h100), 32'h0000_0104, 1, 0));
        vecs.push_back(row(0,1,1,0,3,0,32'h8000_0020,0,0,0, 32'h0000_0020, mem_word(32'h40), 32'h0000_0044, 1, 0));
        vecs.push_back(row(0,1,1,0,4,0,0,0,0,0, 32'h8000_0004, mem_word(32'h20), 32'h0000_0024, 1, 0));
        vecs.push_back(row(0,1,1,0,3,0,32'h8000_0040,0,0,0, 32'h8000_0040, mem_word(32'h8000_0004), 32'h8000_0008, 1, 0));
        vecs.push_back(row(0,1,1,0,3,0,32'h8000_0020,0,0,0, 32'h8000_0020, mem_word(32'h8000_0040), 32'h8000_0044, 1, 0));
        // taken branch overrides PC_Write=0
        vecs.push_back(row(0,0,1,0,0,0,0,1,32'h8000_0300,0, 32'h8000_0300, mem_word(32'h8000_0020), 32'h8000_0024, 1, 0));
        // interrupt take at 0x200, then XADR, then ignored supervisor IRQ
        vecs.push_back(row(0,1,1,0,2,26'h80,0,0,0,0, 32'h0000_0200, mem_word(32'h8000_0300), 32'h8000_0304, 1, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,1, 32'h0000_0200, 0, 32'h0000_0200, 1, 1));
        vecs.push_back(row(0,1,1,0,5,0,0,0,0,0, 32'h8000_0008, mem_word(32'h200), 32'h0000_0204, 1, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,1, 32'h8000_000C, mem_word(32'h8000_0008), 32'h8000_000C, 1, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h8000_0010, mem_word(32'h8000_000C), 32'h8000_0010, 1, 0));
        // interrupt blocked by flush, taken on the next clean cycle
        vecs.push_back(row(0,1,1,0,3,0,32'h0000_0300,0,0,0, 32'h0000_0300, mem_word(32'h8000_0010), 32'h8000_0014, 1, 0));
        vecs.push_back(row(0,1,1,1,0,0,0,0,0,1, 32'h0000_0304, 0, 32'h0000_0304, 0, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h0000_0304, 0, 32'h0000_0304, 1, 1));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h0000_0308, mem_word(32'h304), 32'h0000_0308, 1, 0));
        // PC4 wrap inside user and supervisor half-spaces
        vecs.push_back(row(0,1,1,0,3,0,32'h7FFF_FFFC,0,0,0, 32'h7FFF_FFFC, mem_word(32'h308), 32'h0000_030C, 1, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h0000_0000, mem_word(32'h7FFF_FFFC), 32'h0000_0000, 1, 0));
        vecs.push_back(row(0,1,1,0,4,0,0,0,0,0, 32'h8000_0004, mem_word(32'h0), 32'h0000_0004, 1, 0));
        vecs.push_back(row(0,1,1,0,3,0,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC, mem_word(32'h8000_0004), 32'h8000_0008, 1, 0));
        vecs.push_back(row(0,1,1,0,0,0,0,0,0,0, 32'h8000_0000, mem_word(32'hFFFF_FFFC), 32'h8000_0000, 1, 0));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; pc_write = vecs[i].pcw; ifid_write = vecs[i].ifw;
            flush = vecs[i].fl; pcsrc = vecs[i].src; jt = vecs[i].jt; jr = vecs[i].jr;
            idpc4 = 32'd0; br = vecs[i].br; brt = vecs[i].brt; irq = vecs[i].irq;
            tick();
            check($sformatf("row%0d pc", i),    imem_addr, vecs[i].e_pc);
            check($sformatf("row%0d instr", i), o_instr,   vecs[i].e_instr);
            check($sformatf("row%0d pc4", i),   o_pc4,     vecs[i].e_pc4);
            check($sformatf("row%0d valid", i), {31'd0, o_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("row%0d irq", i),   {31'd0, o_irq},   {31'd0, vecs[i].e_irq});
        end

        // Pending IRQ held across a stall, then wiped by reset.
        idle(); pcsrc = 3'd3; jr = 32'h0000_0500; tick(); check_model("seq jr");
        idle(); irq = 1'b1; ifid_write = 1'b0; pc_write = 1'b0; tick(); check_model("seq stall");
        idle(); rst = 1'b1; tick(); check_model("seq reset");
        idle(); pcsrc = 3'd3; jr = 32'h0000_0600; tick(); check_model("seq jr2");
        idle(); tick(); check_model("seq run");
        check("seq no stale irq", {31'd0, o_irq}, 32'd0);

        // Randomized cycles against the model.
        for (int c = 0; c < 400; c++) begin
            idle();
            rst        = ($urandom_range(0, 63) == 0);
            pc_write   = ($urandom_range(0, 99) < 85);
            ifid_write = ($urandom_range(0, 99) < 85);
            flush      = ($urandom_range(0, 99) < 10);
            pcsrc      = ($urandom_range(0, 99) < 70) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
            jt         = 26'($urandom);
            jr         = $urandom;
            idpc4      = $urandom;
            br         = ($urandom_range(0, 99) < 8);
            brt        = $urandom;
            irq        = ($urandom_range(0, 99) < 15);
            tick();
            check_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
